// File: rtl/slow_adc_pkg.sv
// Shared definitions for the slow-ADC FIFO reader: record field layout, packet framing, FSM states.
// Packet length depends on SLOW_READER_CHECKSUM_EN.
package slow_adc_pkg;

    localparam int REC_W = 64;

    localparam int SC_BIT     = 63;
    localparam int OC_BIT     = 62;
    localparam int TC_EXT_LSB = 48;
    localparam int TC_EXT_W   = 14;
    localparam int TC_INT_LSB = 36;
    localparam int TC_INT_W   = 12;
    localparam int SADC1_LSB  = 18;
    localparam int SADC2_LSB  = 0;
    localparam int SADC_W     = 18;
    localparam int TEMP_W     = 16;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    localparam int PKT_LEN_BASE = 9;
    localparam int PKT_LEN_CSUM = 10;

`ifdef SLOW_READER_CHECKSUM_EN
    localparam int PKT_LEN = PKT_LEN_CSUM;

    function automatic logic [7:0] xor_bytes(input logic [REC_W-1:0] rec);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < REC_W / 8; i++) begin
            acc = acc ^ rec[i*8 +: 8];
        end
        return acc;
    endfunction
`else
    localparam int PKT_LEN = PKT_LEN_BASE;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LATCH,
        ST_SEND,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/slow_adc_record_decode.sv
// Combinational split of one 64-bit slow-ADC record into flags, sign-extended temperatures and raw codes.
module slow_adc_record_decode
    import slow_adc_pkg::*;
(
    input  logic [REC_W-1:0]  record,
    output logic              fault_sc,
    output logic              fault_oc,
    output logic [TEMP_W-1:0] tc_ext_temp,
    output logic [TEMP_W-1:0] tc_int_temp,
    output logic [SADC_W-1:0] sadc1_data,
    output logic [SADC_W-1:0] sadc2_data
);

    assign fault_sc    = record[SC_BIT];
    assign fault_oc    = record[OC_BIT];
    assign tc_ext_temp = {{(TEMP_W - TC_EXT_W){record[TC_EXT_LSB + TC_EXT_W - 1]}},
                          record[TC_EXT_LSB +: TC_EXT_W]};
    assign tc_int_temp = {{(TEMP_W - TC_INT_W){record[TC_INT_LSB + TC_INT_W - 1]}},
                          record[TC_INT_LSB +: TC_INT_W]};
    assign sadc1_data  = record[SADC1_LSB +: SADC_W];
    assign sadc2_data  = record[SADC2_LSB +: SADC_W];

endmodule

// File: rtl/slow_adc_fifo_reader.sv
// Pops slow-ADC records from a normal-mode FIFO, publishes decoded fields and streams each record as a
// header-framed byte packet. Defining SLOW_READER_CHECKSUM_EN appends an XOR checksum byte.
//
//   state    | meaning
//   IDLE     | waiting for a word; read request issued here
//   POP      | FIFO read latency cycle
//   LATCH    | capture word, update decoded outputs, load header
//   SEND     | stream header, record bytes (and checksum)
//   FLUSH    | one cycle after an abort while the FIFO clears
module slow_adc_fifo_reader
    import slow_adc_pkg::*;
(
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              flush,
    output logic              fifo_rdreq,
    input  logic [REC_W-1:0]  fifo_rddata,
    input  logic              fifo_rdempty,
    output logic              fifo_clr,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [TEMP_W-1:0] tc_ext_temp,
    output logic [TEMP_W-1:0] tc_int_temp,
    output logic [SADC_W-1:0] sadc1_data,
    output logic [SADC_W-1:0] sadc2_data,
    output logic              fault_sc,
    output logic              fault_oc,
    output logic              sample_valid,
    output logic [15:0]       record_count
);

    state_t             state;
    logic [REC_W-1:0]   rec_shift;
    logic [3:0]         byte_idx;
`ifdef SLOW_READER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    logic               dec_sc;
    logic               dec_oc;
    logic [TEMP_W-1:0]  dec_ext;
    logic [TEMP_W-1:0]  dec_int;
    logic [SADC_W-1:0]  dec_s1;
    logic [SADC_W-1:0]  dec_s2;

    slow_adc_record_decode u_decode (
        .record      (fifo_rddata),
        .fault_sc    (dec_sc),
        .fault_oc    (dec_oc),
        .tc_ext_temp (dec_ext),
        .tc_int_temp (dec_int),
        .sadc1_data  (dec_s1),
        .sadc2_data  (dec_s2)
    );

    // Issued combinationally from IDLE so the read can never outlive IDLE or race an empty flag.
    assign fifo_rdreq = (state == ST_IDLE) && !fifo_rdempty && !flush;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rec_shift    <= '0;
            byte_idx     <= '0;
            fifo_clr     <= 1'b0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            tc_ext_temp  <= '0;
            tc_int_temp  <= '0;
            sadc1_data   <= '0;
            sadc2_data   <= '0;
            fault_sc     <= 1'b0;
            fault_oc     <= 1'b0;
            sample_valid <= 1'b0;
            record_count <= 16'h0000;
`ifdef SLOW_READER_CHECKSUM_EN
            csum         <= 8'h00;
`endif
        end else begin
            fifo_clr     <= 1'b0;
            sample_valid <= 1'b0;
            if (flush) begin
                state    <= ST_FLUSH;
                tx_valid <= 1'b0;
                fifo_clr <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!fifo_rdempty) state <= ST_POP;
                    end
                    ST_POP: begin
                        state <= ST_LATCH;
                    end
                    ST_LATCH: begin
                        rec_shift    <= fifo_rddata;
                        fault_sc     <= dec_sc;
                        fault_oc     <= dec_oc;
                        tc_ext_temp  <= dec_ext;
                        tc_int_temp  <= dec_int;
                        sadc1_data   <= dec_s1;
                        sadc2_data   <= dec_s2;
                        sample_valid <= 1'b1;
                        record_count <= record_count + 16'd1;
`ifdef SLOW_READER_CHECKSUM_EN
                        csum         <= xor_bytes(fifo_rddata);
`endif
                        tx_data      <= HEADER_BYTE;
                        tx_valid     <= 1'b1;
                        byte_idx     <= 4'd0;
                        state        <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (tx_ready) begin
                            if (byte_idx == 4'(PKT_LEN - 1)) begin
                                tx_valid <= 1'b0;
                                state    <= ST_IDLE;
                            end else begin
                                byte_idx <= byte_idx + 4'd1;
`ifdef SLOW_READER_CHECKSUM_EN
                                if (byte_idx == 4'(PKT_LEN_BASE - 1)) begin
                                    tx_data <= csum;
                                end else begin
                                    tx_data   <= rec_shift[REC_W-1 -: 8];
                                    rec_shift <= {rec_shift[REC_W-9:0], 8'h00};
                                end
`else
                                tx_data   <= rec_shift[REC_W-1 -: 8];
                                rec_shift <= {rec_shift[REC_W-9:0], 8'h00};
`endif
                            end
                        end
                    end
                    ST_FLUSH: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
